// File: rtl/seq_sig_pkg.sv
// Shared types and the signature next-state function for the sequential
// signature unit and its compaction register.
package seq_sig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sig_fsm_e;

    localparam logic MODE_XOR  = 1'b0;
    localparam logic MODE_MISR = 1'b1;

    // Widest state the helper can handle; callers zero-extend and truncate.
    localparam int SIG_MAX_W = 64;

    function automatic logic [SIG_MAX_W-1:0] next_sig(
        input logic [SIG_MAX_W-1:0] state,
        input logic [SIG_MAX_W-1:0] din,
        input logic                 mode,
        input logic [SIG_MAX_W-1:0] poly,
        input int unsigned          width
    );
        logic [SIG_MAX_W-1:0] mask;
        logic [SIG_MAX_W-1:0] msb_vec;
        logic [SIG_MAX_W-1:0] shifted;
        mask    = {SIG_MAX_W{1'b1}} >> (SIG_MAX_W - width);
        msb_vec = state >> (width - 1);
        shifted = (state << 1) ^ (msb_vec[0] ? poly : '0);
        if (mode == MODE_XOR) begin
            return (state ^ din) & mask;
        end
        return (shifted ^ din) & mask;
    endfunction

endpackage

// File: rtl/seq_sig_misr.sv
// WIDTH-bit compaction register: loads the seed, or advances by one word in
// XOR-accumulate or MISR mode when enabled.
module seq_sig_misr
    import seq_sig_pkg::*;
#(
    parameter int               WIDTH = 19,
    parameter logic [WIDTH-1:0] POLY  = 19'h00027,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    assign next_state = WIDTH'(next_sig(SIG_MAX_W'(state), SIG_MAX_W'(in), mode,
                                        SIG_MAX_W'(POLY), WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
        end else if (load) begin
            state <= SEED;
        end else if (en) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/seq_signature_unit.sv
// Signature capture unit: compacts len valid words after start, then
// publishes the signature and a golden-compare flag with a one-cycle done.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | compacting valid words until len have been consumed
// DONE  | one-cycle done pulse; start here begins the next run at once
module seq_signature_unit
    import seq_sig_pkg::*;
#(
    parameter int               WIDTH = 19,
    parameter int               OUT_W = 1,
    parameter logic [WIDTH-1:0] POLY  = 19'h00027,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             match
);

    sig_fsm_e         fsm_q, fsm_d;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] len_q;
    logic [WIDTH-1:0] golden_q;
    logic             mode_q;
    logic             load_seed;
    logic             advance;
    logic             finish_run;
    logic [WIDTH-1:0] misr_state;
    logic [WIDTH-1:0] misr_next;

    seq_sig_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk        (clk),
        .reset      (reset),
        .load       (load_seed),
        .en         (advance),
        .mode       (mode_q),
        .in         (in),
        .state      (misr_state),
        .next_state (misr_next)
    );

    always_comb begin
        fsm_d      = fsm_q;
        load_seed  = 1'b0;
        advance    = 1'b0;
        finish_run = 1'b0;
        case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    load_seed = 1'b1;
                    fsm_d     = (len == '0) ? DONE : RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                if (in_valid) begin
                    advance = 1'b1;
                    if (count_q == len_q - LEN_W'(1)) begin
                        finish_run = 1'b1;
                        fsm_d      = DONE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= IDLE;
            count_q   <= '0;
            len_q     <= '0;
            golden_q  <= '0;
            mode_q    <= MODE_XOR;
            signature <= '0;
            match     <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            if (load_seed) begin
                mode_q   <= mode;
                len_q    <= len;
                golden_q <= golden;
                count_q  <= '0;
                // An empty run completes immediately with the seed as result.
                if (len == '0) begin
                    signature <= SEED;
                    match     <= (golden == SEED);
                end
            end
            if (advance) begin
                count_q <= count_q + LEN_W'(1);
            end
            if (finish_run) begin
                signature <= misr_next;
                match     <= (misr_next == golden_q);
            end
        end
    end

    assign out  = misr_state[OUT_W-1:0];
    assign busy = (fsm_q == RUN);
    assign done = (fsm_q == DONE);

endmodule
